// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned MUL_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_NEG  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  // Magnitude of an operand; 0x8000_0000 maps to itself as an unsigned value.
  function automatic logic [MUL_W-1:0] mag(input logic [MUL_W-1:0] x,
                                           input logic            is_signed);
    logic [MUL_W-1:0] r;
    r = x;
    if (is_signed && x[MUL_W-1]) begin
      r = MUL_W'(~x + MUL_W'(1));
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Ripple-carry adder built from a chain of full_adder cells.
module adder_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_i;
  assign c_o      = carry[WIDTH];

  // Carry ripples LSB to MSB through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell of the ripple chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mul_unit_32bit.sv
// Multi-cycle RV32M multiplier: sign-magnitude shift-and-add over 32
// iterations with one shared ripple adder, then an optional 64-bit negate.
module mul_unit_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic             done_o,
  output logic             busy_o
);

  import mul_pkg::*;

  localparam int unsigned PW = 2 * WIDTH;

  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  p_d;
  logic              done_d;
  logic              busy_d;

  logic [WIDTH-1:0]  sum;
  logic              carry;
  logic [WIDTH:0]    acc;
  logic [PW-1:0]     prod;
  logic              a_signed;
  logic              b_signed;

  // Accumulate step: hi + multiplicand, reused every CALC cycle.
  adder_32bit #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i (hi_q),
    .b_i (mcand_q),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (carry)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    p_d      = p_o;
    done_d   = 1'b0;
    acc      = '0;
    prod     = '0;
    a_signed = 1'b0;
    b_signed = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_signed = (op_i == MULH) || (op_i == MULHSU);
          b_signed = (op_i == MULH);
          op_d     = mul_op_e'(op_i);
          neg_d    = (a_signed & a_i[WIDTH-1]) ^ (b_signed & b_i[WIDTH-1]);
          mcand_d  = mag(a_i, a_signed);
          lo_d     = mag(b_i, b_signed);
          hi_d     = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        acc   = lo_q[0] ? {carry, sum} : {1'b0, hi_q};
        hi_d  = acc[WIDTH:1];
        lo_d  = {acc[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = ST_NEG;
        end
      end

      ST_NEG: begin
        prod = {hi_q, lo_q};
        if (neg_q) begin
          prod = ~prod + PW'(1);
        end
        hi_d    = prod[PW-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        p_d     = (op_q == MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= MUL;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_o     <= '0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_o     <= p_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
    end
  end

endmodule

// File: doc/mul_unit_32bit.md
# mul_unit_32bit

Multi-cycle 32-bit shift-and-add multiplier for the CPU execute stage, implementing RV32M MUL/MULH/MULHSU/MULHU. It is the additive counterpart of the ripple subtractor datapath: one 32-bit ripple adder is reused for 32 iterations under a small FSM. The execute stage stalls on `busy_o` and captures `p_o` on `done_o`.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported and verified.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request pulse; accepted only when `busy_o`=0.
- `op_i`  in  2  operation: 00 MUL (low 32 bits), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- `a_i`  in  32  multiplicand (rs1).
- `b_i`  in  32  multiplier (rs2).
- `p_o`  out  32  result; valid from the `done_o` cycle, held until the next accepted start.
- `done_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high while state ≠ IDLE.

## Operation
- States: IDLE → CALC → NEG → DONE → IDLE.
- IDLE: if `start_i`, latch `op_i`; compute `neg = (a_signed & a_i[31]) ^ (b_signed & b_i[31])`. `a_signed` = op∈{01,10}; `b_signed` = op==01. Load multiplicand register with |a|, low product half with |b|, high half with 0, iteration counter with 0. Magnitude of 0x8000_0000 is 0x8000_0000 (unsigned 32-bit).
- CALC (32 cycles): if `lo[0]`, `{c,hi} = hi + mcand` via the adder (33-bit result incl. carry-out); else `{c,hi} = {0,hi}`. Then `{hi,lo} = {c,hi,lo} >> 1`. Counter increments; leave CALC after count 31.
- NEG (1 cycle, always traversed for fixed latency): if `neg`, `{hi,lo} = ~{hi,lo} + 1` (64-bit two's complement); else unchanged.
- DONE: `p_o` = `lo` for MUL, `hi` otherwise; `done_o`=1; next state IDLE.
- `start_i` while `busy_o`=1 is ignored (no queueing, no effect on current operation).
- Operand inputs are sampled only in the accepting cycle; later changes have no effect.

## Timing
- Reset: state IDLE, `p_o`=0, `done_o`=0, `busy_o`=0, all internal registers 0.
- Start accepted at edge N (IDLE, `start_i`=1): CALC N+1..N+32, NEG N+33, DONE N+34 (`done_o`=1, `p_o` valid). IDLE at N+35, earliest next accept at edge N+35.
- Fixed latency 34 cycles regardless of operands or op.
- `busy_o` high cycles N+1..N+34 inclusive.
- `rst_i` during any state: next cycle IDLE, outputs at reset values, no `done_o` for the aborted op.
- `start_i` and `rst_i` together: reset wins.

## Structure
- Package `mul_pkg`: `mul_op_e` (MUL, MULH, MULHSU, MULHU = 2'b00..2'b11), `mul_state_e`, `MUL_ITER` = 32.
- Sub-module `adder_32bit` (ripple chain of `full_adder`, ports `a_i`, `b_i`, `c_i`, `s_o`, `c_o`), instantiated once for the CALC accumulate step. Negation uses a separate behavioural 64-bit increment.
- Single FSM plus datapath registers in `mul_unit_32bit`; no other hierarchy.

## Test plan
- Reset then idle: `p_o`=0, `done_o`=0, `busy_o`=0. MUL 7×6 → `done_o` exactly 34 cycles after start, `p_o`=0x0000_002A.
- MUL a=0xFFFF_FFFD (−3), b=5 → `p_o`=0xFFFF_FFF1. MULH 0x8000_0000×0x8000_0000 → `p_o`=0x4000_0000.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → `p_o`=0xFFFF_FFFE. MULHSU a=0xFFFF_FFFF (−1), b=0xFFFF_FFFF → `p_o`=0xFFFF_FFFF.
- Start MUL 3×4; pulse `start_i` with 9×9 at CALC cycle 10 → ignored; `p_o`=0x0000_000C, single `done_o`.
- Start MULHU; assert `rst_i` at CALC cycle 20 → IDLE next cycle, no `done_o`; a new MUL 2×2 then yields `p_o`=4 after 34 cycles.
- Back-to-back: start at first IDLE cycle after DONE → accepted; `p_o` holds the previous result until the new `done_o`.
